// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    // Architectural register width seen by the core.
    typedef logic [31:0] op_t;

    // Operation selector driven by the decoder.
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    // One radix-2 step per operand bit.
    localparam int unsigned MulDivIters = 32;

    // LO value reported for a zero divisor.
    localparam op_t DivZeroQuotient = 32'hFFFF_FFFF;

    // True for the two's-complement flavours (MULT, DIV).
    function automatic logic md_is_signed(md_op_t o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

    // True for DIV and DIVU.
    function automatic logic md_is_div(md_op_t o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate used when committing a result.
// Wide mode negates the full 2*Width product; narrow mode negates the
// upper (remainder) and lower (quotient) halves independently.
module md_sign_fix #(
    parameter int unsigned Width = 32
) (
    input  logic [2*Width-1:0] data_i,
    input  logic               wide_i,
    input  logic               neg_wide_i,
    input  logic               neg_hi_i,
    input  logic               neg_lo_i,
    output logic [2*Width-1:0] data_o
);

    logic [Width-1:0] hi_half;
    logic [Width-1:0] lo_half;

    // Select full-width or per-half negation.
    always_comb begin
        hi_half = data_i[2*Width-1:Width];
        lo_half = data_i[Width-1:0];
        data_o  = data_i;
        if (wide_i) begin
            data_o = neg_wide_i ? (-data_i) : data_i;
        end else begin
            data_o[2*Width-1:Width] = neg_hi_i ? (-hi_half) : hi_half;
            data_o[Width-1:0]       = neg_lo_i ? (-lo_half) : lo_half;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit owning HI/LO.
// Multiply: right-shifting shift-add with the multiplier in the low half
// of the work register. Divide: restoring division on {remainder, quotient}.
// Both run on magnitudes; signs are restored in the FIX cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  md_op_t op,
    input  op_t    a,
    input  op_t    b,
    input  logic   hi_we,
    input  logic   lo_we,
    input  op_t    wdata,
    output logic   busy,
    output logic   done,
    output op_t    hi,
    output op_t    lo
);

    localparam int unsigned CntW = $clog2(MulDivIters);
    localparam logic [CntW-1:0] CntMax = CntW'(MulDivIters - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    md_op_t               op_q;
    logic [2*Width-1:0]   work_q;
    logic [Width-1:0]     opb_q;      // multiplicand or divisor magnitude
    logic [Width-1:0]     a_raw_q;    // original dividend for divide-by-zero
    logic                 prod_neg_q; // product / quotient sign
    logic                 rem_neg_q;  // remainder sign
    logic                 divzero_q;
    logic                 busy_q;
    logic                 done_q;
    op_t                  hi_q;
    op_t                  lo_q;

    logic                 start_signed;
    logic                 start_div;
    logic [Width-1:0]     mag_a;
    logic [Width-1:0]     mag_b;
    logic [Width:0]       mul_sum;
    logic [Width:0]       div_rem;
    logic [Width+1:0]     div_diff;
    logic [2*Width-1:0]   step_next;
    logic                 calc_div;
    logic [2*Width-1:0]   fixed;

    // Operand magnitudes and op class for the start cycle.
    always_comb begin
        start_signed = md_is_signed(op);
        start_div    = md_is_div(op);
        mag_a        = (start_signed && a[Width-1]) ? (-a) : a;
        mag_b        = (start_signed && b[Width-1]) ? (-b) : b;
    end

    // One radix-2 iteration of whichever algorithm is running.
    always_comb begin
        calc_div = md_is_div(op_q);
        mul_sum  = {1'b0, work_q[2*Width-1:Width]}
                 + (work_q[0] ? {1'b0, opb_q} : {(Width+1){1'b0}});
        // Shift the next dividend bit into the partial remainder.
        div_rem  = {work_q[2*Width-1:Width], work_q[Width-1]};
        div_diff = {1'b0, div_rem} - {2'b00, opb_q};
        if (calc_div) begin
            if (!div_diff[Width+1]) begin
                step_next = {div_diff[Width-1:0], work_q[Width-2:0], 1'b1};
            end else begin
                step_next = {div_rem[Width-1:0], work_q[Width-2:0], 1'b0};
            end
        end else begin
            step_next = {mul_sum, work_q[Width-1:1]};
        end
    end

    md_sign_fix #(
        .Width (Width)
    ) u_sign_fix (
        .data_i     (work_q),
        .wide_i     (!calc_div),
        .neg_wide_i (prod_neg_q),
        .neg_hi_i   (rem_neg_q),
        .neg_lo_i   (prod_neg_q),
        .data_o     (fixed)
    );

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= MD_MULT;
            work_q     <= '0;
            opb_q      <= '0;
            a_raw_q    <= '0;
            prod_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            divzero_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // MTHI/MTLO land here; a same-edge start is overwritten at FIX.
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        op_q       <= op;
                        a_raw_q    <= a;
                        prod_neg_q <= start_signed & (a[Width-1] ^ b[Width-1]);
                        rem_neg_q  <= start_signed & a[Width-1];
                        divzero_q  <= start_div && (b == '0);
                        if (start_div) begin
                            work_q <= {{Width{1'b0}}, mag_a};
                            opb_q  <= mag_b;
                        end else begin
                            work_q <= {{Width{1'b0}}, mag_b};
                            opb_q  <= mag_a;
                        end
                        cnt_q   <= CntMax;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    work_q <= step_next;
                    if (cnt_q == '0) begin
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StFix: begin
                    if (divzero_q) begin
                        hi_q <= a_raw_q;
                        lo_q <= DivZeroQuotient;
                    end else begin
                        hi_q <= fixed[2*Width-1:Width];
                        lo_q <= fixed[Width-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
